// File: rtl/io_read_ctrl.sv
// Load-path controller: decodes the CPU load address, strobes the selected read
// target, waits out that target's latency, then returns one registered response.
module io_read_ctrl #(
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned IMG_LAT = 2
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          rd_req_i,
    input  logic [23:0]   address_i,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic [DW-1:0] orig_rdata_i,
    input  logic [DW-1:0] proc_rdata_i,
    output logic          mem_rd_o,
    output logic          orig_rd_o,
    output logic          proc_rd_o,
    output logic          stall_o,
    output logic          rvalid_o,
    output logic [DW-1:0] rdata_o,
    output logic          rd_err_o
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;
    typedef enum logic [1:0] {RegNone, RegMem, RegOrig, RegProc} region_e;

    localparam logic [2:0] MemLatC = 3'(MEM_LAT);
    localparam logic [2:0] ImgLatC = 3'(IMG_LAT);

    state_e        state_q;
    region_e       region_q;
    region_e       region_live;
    logic [2:0]    cnt_q;
    logic [DW-1:0] rdata_q;
    logic          rvalid_q;
    logic          rd_err_q;
    logic          idle_req;

    // Process window is checked first so it wins any overlap with other ranges.
    always_comb begin
        region_live = RegNone;
        if (address_i >= 24'd130 && address_i <= 24'd140) begin
            region_live = RegProc;
        end else if (address_i >= 24'd120 && address_i < 24'd130) begin
            region_live = RegOrig;
        end else if (address_i <= 24'd96) begin
            region_live = RegMem;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            region_q <= RegNone;
            cnt_q    <= 3'd0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (rd_req_i) begin
                        if (region_live == RegNone) begin
                            rdata_q  <= '0;
                            rd_err_q <= 1'b1;
                            rvalid_q <= 1'b1;
                            state_q  <= StResp;
                        end else begin
                            region_q <= region_live;
                            cnt_q    <= (region_live == RegMem) ? MemLatC : ImgLatC;
                            state_q  <= StWait;
                        end
                    end
                end
                StWait: begin
                    // Last wait cycle: target data is valid now, capture via latched region.
                    if (cnt_q <= 3'd1) begin
                        case (region_q)
                            RegMem:  rdata_q <= mem_rdata_i;
                            RegOrig: rdata_q <= orig_rdata_i;
                            RegProc: rdata_q <= proc_rdata_i;
                            default: rdata_q <= '0;
                        endcase
                        rd_err_q <= 1'b0;
                        rvalid_q <= 1'b1;
                        cnt_q    <= 3'd0;
                        state_q  <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign idle_req  = (state_q == StIdle) && rd_req_i;
    assign mem_rd_o  = idle_req && (region_live == RegMem);
    assign orig_rd_o = idle_req && (region_live == RegOrig);
    assign proc_rd_o = idle_req && (region_live == RegProc);
    assign stall_o   = idle_req || (state_q == StWait);
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign rd_err_o  = rd_err_q;

endmodule

// File: tb/tb_io_read_ctrl.sv
// Directed bench for io_read_ctrl: latency-accurate target models and a response
// scoreboard checked against every rvalid.
module tb_io_read_ctrl;

    localparam int DW      = 32;
    localparam int MEM_LAT = 1;
    localparam int IMG_LAT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          rd_req;
    logic [23:0]   address;
    logic [DW-1:0] mem_rdata, orig_rdata, proc_rdata;
    logic          mem_rd, orig_rd, proc_rd, stall, rvalid, rd_err;
    logic [DW-1:0] rdata;

    logic [DW-1:0] mem_val, orig_val, proc_val;
    logic [7:0]    mem_pipe = '0;
    logic [7:0]    orig_pipe = '0;
    logic [7:0]    proc_pipe = '0;
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_err = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            cyc;
    } exp_t;
    exp_t sb[$];

    io_read_ctrl #(.DW(DW), .MEM_LAT(MEM_LAT), .IMG_LAT(IMG_LAT)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .rd_req_i    (rd_req),
        .address_i   (address),
        .mem_rdata_i (mem_rdata),
        .orig_rdata_i(orig_rdata),
        .proc_rdata_i(proc_rdata),
        .mem_rd_o    (mem_rd),
        .orig_rd_o   (orig_rd),
        .proc_rd_o   (proc_rd),
        .stall_o     (stall),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .rd_err_o    (rd_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Targets present valid data exactly LAT cycles after their strobe, junk otherwise.
    always @(posedge clk) begin
        mem_pipe  <= {mem_pipe[6:0], mem_rd};
        orig_pipe <= {orig_pipe[6:0], orig_rd};
        proc_pipe <= {proc_pipe[6:0], proc_rd};
    end
    assign mem_rdata  = mem_pipe[MEM_LAT-1]  ? mem_val  : ~mem_val;
    assign orig_rdata = orig_pipe[IMG_LAT-1] ? orig_val : ~orig_val;
    assign proc_rdata = proc_pipe[IMG_LAT-1] ? proc_val : ~proc_val;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("no_rvalid", {63'd0, rvalid}, 64'd0);
        end else if (rvalid) begin
            e = sb.pop_front();
            chk("rdata", {32'd0, rdata}, {32'd0, e.data});
            chk("rd_err", {63'd0, rd_err}, {63'd0, e.err});
            chk("rvalid_cycle", 64'(cyc), 64'(e.cyc));
        end
    end

    // cls: 0 unmapped, 1 mem, 2 orig, 3 proc
    task automatic do_read(input logic [23:0] addr, input int cls, input bit hold, input bit chg);
        logic [2:0]    strb;
        logic [DW-1:0] data;
        logic          err;
        int            lat;
        exp_t          e;
        case (cls)
            1:       begin strb = 3'b100; data = mem_val;  err = 1'b0; lat = MEM_LAT; end
            2:       begin strb = 3'b010; data = orig_val; err = 1'b0; lat = IMG_LAT; end
            3:       begin strb = 3'b001; data = proc_val; err = 1'b0; lat = IMG_LAT; end
            default: begin strb = 3'b000; data = '0;       err = 1'b1; lat = 0;       end
        endcase
        @(negedge clk);
        rd_req  = 1'b1;
        address = addr;
        #1;
        chk($sformatf("strobe@%0d", addr), {61'd0, mem_rd, orig_rd, proc_rd}, {61'd0, strb});
        chk($sformatf("stall_T@%0d", addr), {63'd0, stall}, 64'd1);
        e.data = data;
        e.err  = err;
        e.cyc  = cyc + lat + 1;
        sb.push_back(e);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (chg && k == 1) address = 24'd40;
            #1;
            chk($sformatf("strobe_off@%0d", addr), {61'd0, mem_rd, orig_rd, proc_rd}, 64'd0);
            chk($sformatf("stall_%0d@%0d", k, addr), {63'd0, stall}, {63'd0, k <= lat});
            if (k == lat + 1) begin
                chk($sformatf("rvalid@%0d", addr), {63'd0, rvalid}, 64'd1);
                if (!hold) rd_req = 1'b0;
            end
        end
    endtask

    logic [23:0] b_addr[9] = '{24'd96, 24'd97, 24'd119, 24'd120, 24'd129,
                               24'd130, 24'd140, 24'd141, 24'hFFFFFF};
    int          b_cls[9]  = '{1, 0, 0, 2, 2, 3, 3, 0, 0};

    initial begin
        reset    = 1'b1;
        rd_req   = 1'b0;
        address  = '0;
        mem_val  = 32'hDEADBEEF;
        orig_val = 32'h11112222;
        proc_val = 32'h33334444;
        #1;
        chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
        chk("rst_rdata", {32'd0, rdata}, 64'd0);
        chk("rst_rd_err", {63'd0, rd_err}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_strobes", {61'd0, mem_rd, orig_rd, proc_rd}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        do_read(24'd40, 1, 1'b0, 1'b0);
        do_read(24'd125, 2, 1'b0, 1'b0);
        do_read(24'd135, 3, 1'b0, 1'b0);

        for (int i = 0; i < 9; i++) begin
            mem_val  = 32'hA0000000 + 32'(i);
            orig_val = 32'hB0000000 + 32'(i);
            proc_val = 32'hC0000000 + 32'(i);
            do_read(b_addr[i], b_cls[i], 1'b0, 1'b0);
        end

        do_read(24'd98, 0, 1'b0, 1'b0);
        do_read(24'd200, 0, 1'b0, 1'b0);
        mem_val = 32'h0BADF00D;
        do_read(24'd0, 1, 1'b0, 1'b0);

        orig_val = 32'h5A5A1234;
        mem_val  = 32'h77778888;
        do_read(24'd125, 2, 1'b0, 1'b1);

        // Request held through RESP: the next strobe lands only in the following IDLE cycle.
        mem_val  = 32'h12345678;
        proc_val = 32'h87654321;
        do_read(24'd40, 1, 1'b1, 1'b0);
        do_read(24'd130, 3, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        chk("idle_stall", {63'd0, stall}, 64'd0);
        chk("idle_strobes", {61'd0, mem_rd, orig_rd, proc_rd}, 64'd0);

        // Reset in the middle of WAIT: read is dropped, outputs clear at once.
        mem_val = 32'hCAFEF00D;
        do_read(24'd10, 1, 1'b0, 1'b0);
        orig_val = 32'h0F0F0F0F;
        @(negedge clk);
        rd_req  = 1'b1;
        address = 24'd125;
        @(negedge clk);
        sb.delete();
        rd_req = 1'b0;
        reset  = 1'b1;
        #1;
        chk("midwait_rdata", {32'd0, rdata}, 64'd0);
        chk("midwait_rd_err", {63'd0, rd_err}, 64'd0);
        chk("midwait_rvalid", {63'd0, rvalid}, 64'd0);
        chk("midwait_stall", {63'd0, stall}, 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        orig_val = 32'h600DCAFE;
        do_read(24'd125, 2, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        #2;
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/io_read_ctrl.md
IO_READ_CTRL -- requirements
Module: io_read_ctrl

Interface
REQ-001 SHALL have parameter DW, default 32, read data width.
REQ-002 SHALL have parameter MEM_LAT, default 1, data memory read latency in cycles (1..7).
REQ-003 SHALL have parameter IMG_LAT, default 2, original/process image buffer read latency in cycles (1..7).
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port rd_req  in  1  CPU load request, held high until rvalid.
REQ-007 SHALL have port address  in  24  CPU load address.
REQ-008 SHALL have port mem_rdata  in  DW  data memory read data.
REQ-009 SHALL have port orig_rdata  in  DW  original-image buffer read data.
REQ-010 SHALL have port proc_rdata  in  DW  processed-image buffer read data.
REQ-011 SHALL have port mem_rd, orig_rd, proc_rd  out  1 each  one-cycle read strobes to targets.
REQ-012 SHALL have port stall  out  1  CPU pipeline hold.
REQ-013 SHALL have port rvalid  out  1  one-cycle read-data-valid pulse.
REQ-014 SHALL have port rdata  out  DW  registered load result.
REQ-015 SHALL have port rd_err  out  1  unmapped-read flag, valid with rvalid.

Function
REQ-016 SHALL decode read region with priority: process (130 <= address <= 140), original (120 <= address < 130), mem (address <= 96); every other address (97..119, > 140, including display range) SHALL be unmapped for reads.
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-018 In IDLE with rd_req=1 and mapped address (cycle T): SHALL assert the matching strobe combinationally for cycle T only, latch address region, load latency counter with MEM_LAT or IMG_LAT, go to WAIT.
REQ-019 In IDLE with rd_req=1 and unmapped address: SHALL assert no strobe, go directly to RESP with rdata=0, rd_err=1.
REQ-020 In WAIT: counter SHALL decrement each cycle; target data SHALL be captured into rdata at the rising edge ending cycle T+LAT, then go to RESP.
REQ-021 Capture source SHALL be chosen by the latched region, not the live address; address changes during WAIT SHALL have no effect.
REQ-022 In RESP: rvalid=1 for exactly one cycle, rd_err valid, then unconditionally go to IDLE; rd_req in RESP SHALL be ignored (no back-to-back acceptance; minimum one IDLE cycle between requests).
REQ-023 stall SHALL be 1 when (IDLE and rd_req=1) or state=WAIT; 0 in RESP and in IDLE with rd_req=0.
REQ-024 Mapped read latency: strobe at T, rvalid at T+LAT+1, stall high T..T+LAT; unmapped: stall high T only, rvalid at T+1.
REQ-025 rdata and rd_err SHALL hold their last value until the next capture; rd_err SHALL clear to 0 on any mapped capture.
REQ-026 At most one strobe SHALL be high in any cycle; strobes SHALL be 0 outside IDLE.
REQ-027 rd_req=0 in IDLE SHALL leave all state unchanged.

Reset
REQ-028 reset=1 SHALL immediately (asynchronously) force state=IDLE, counter=0, rdata=0, rvalid=0, rd_err=0, region=none; stall and strobes then follow REQ-023/026 combinationally.
REQ-029 reset during WAIT or RESP SHALL abort the read with no rvalid; the first request after reset release SHALL be handled normally.

Verification
REQ-030 Mem read: address=40, mem_rdata=0xDEADBEEF, MEM_LAT=1, rd_req high at T -> mem_rd at T only, stall T..T+1, rvalid at T+2, rdata=0xDEADBEEF, rd_err=0.
REQ-031 Image reads: address=125 then 135, IMG_LAT=2 -> orig_rd then proc_rd, rvalid at T+3 each, rdata from correct buffer, address boundaries 119/120/129/130/140/141 decoded per REQ-016.
REQ-032 Unmapped: address=98 and 200 -> no strobe, rvalid at T+1, rdata=0, rd_err=1; following read at address 0 clears rd_err.
REQ-033 Address changed from 125 to 40 during WAIT -> orig_rdata still captured.
REQ-034 Held rd_req through RESP -> second strobe only after one IDLE cycle; exactly one rvalid per accepted request.
REQ-035 reset asserted mid-WAIT -> outputs zero immediately, no rvalid; subsequent read completes per REQ-024.
